dmem_responder: RTL

- Responder side of the MEM-stage data-memory interface: serves the pipeline's load/store requests (MemRead, MemWrite, Address, writeData) with a configurable multi-cycle latency.
- Drives a stall line into the hazard unit so the pipeline freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB while an access is outstanding.
- Replaces the single-cycle data memory in the pipelined core; returns ReadData to the MEM/WB register.

---
 rtl/dmem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: accepts a load/store
// and holds the pipeline stalled for LATENCY cycles before responding.
module dmem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] writeData,
    output logic [31:0] ReadData,
    output logic        stall,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t          stateReg, stateNext;
    logic [3:0]      counterReg, counterNext;
    logic            writeReg, readReg, errFlagReg;
    logic [AW-1:0]   idxReg;
    logic [31:0]     dataReg;
    logic [31:0]     readDataReg;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic [AW-1:0]   liveIdx;
    logic            stallComb;
    logic            enterResp;
    logic            commitWrite, commitRead;
    logic [AW-1:0]   commitIdx;
    logic [31:0]     commitData;
    logic            unusedAddrBits;

    assign req            = MemRead | MemWrite;
    assign liveIdx        = Address[AW+1:2];
    assign unusedAddrBits = ^{Address[31:AW+2], Address[1:0]};

    always_comb begin
        stateNext   = stateReg;
        counterNext = counterReg;
        stallComb   = 1'b0;
        case (stateReg)
            IDLE: begin
                stallComb = req;
                if (req) begin
                    if (LATENCY == 1) begin
                        stateNext = RESP;
                    end else begin
                        stateNext   = WAIT;
                        counterNext = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                stallComb = 1'b1;
                if (counterReg == 4'd0) begin
                    stateNext = RESP;
                end else begin
                    counterNext = counterReg - 4'd1;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // With LATENCY=1 the commit happens straight out of IDLE, before capture.
    always_comb begin
        if (stateReg == IDLE) begin
            commitWrite = MemWrite;
            commitRead  = MemRead & ~MemWrite;
            commitIdx   = liveIdx;
            commitData  = writeData;
        end else begin
            commitWrite = writeReg;
            commitRead  = readReg;
            commitIdx   = idxReg;
            commitData  = dataReg;
        end
    end

    assign enterResp = rst && (stateNext == RESP) && (stateReg != RESP);

    assign stall    = rst & stallComb;
    assign done     = (stateReg == RESP);
    assign err      = (stateReg == RESP) & errFlagReg;
    assign ReadData = readDataReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= IDLE;
            counterReg  <= 4'd0;
            writeReg    <= 1'b0;
            readReg     <= 1'b0;
            errFlagReg  <= 1'b0;
            idxReg      <= '0;
            dataReg     <= 32'd0;
            readDataReg <= 32'd0;
        end else begin
            stateReg   <= stateNext;
            counterReg <= counterNext;
            if (stateReg == IDLE && req) begin
                writeReg   <= MemWrite;
                readReg    <= MemRead & ~MemWrite;
                errFlagReg <= MemRead & MemWrite;
                idxReg     <= liveIdx;
                dataReg    <= writeData;
            end
            if (enterResp && commitRead) begin
                readDataReg <= mem[commitIdx];
            end
        end
    end

    // Array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (enterResp && commitWrite) begin
            mem[commitIdx] <= commitData;
        end
    end

endmodule
